render_scheduler: RTL and testbench
===================================

Name: render_scheduler

Overview:
- Frame-level controller for the ray-tracing renderer pipeline.
- On a start pulse it sweeps every pixel of an H_ACTIVE x V_ACTIVE frame and issues the hcount/vcount pair with a per-frame object-select code into the renderer's input streams.
- It throttles issue with a credit counter bounded by the renderer's in-flight capacity, collects returned pixels and writes them to the framebuffer.
- It reports frame completion once every issued pixel has returned.

Parameters:
- H_ACTIVE, 320, pixels per line; hcount range 0..H_ACTIVE-1.
- V_ACTIVE, 180, lines per frame; vcount range 0..V_ACTIVE-1.
- MAX_INFLIGHT, 384, maximum outstanding pixels (issued, not yet returned); must exceed renderer latency 339.
- FB_ADDR_W, 16, framebuffer address width; must satisfy 2^FB_ADDR_W >= H_ACTIVE*V_ACTIVE.

Ports:
- aclk  in  1  clock
- areset  in  1  reset, asynchronous, active-high
- start  in  1  frame start request, sampled in IDLE only
- select_objs_cfg  in  2  object-select code, latched at accepted start
- busy  out  1  high in ISSUE or DRAIN
- frame_done  out  1  one-cycle pulse at frame completion
- hcount_axis_tdata  out  11  issued pixel column
- hcount_axis_tvalid  out  1  issue valid
- hcount_axis_tready  in  1  renderer accepts hcount
- vcount_axis_tdata  out  10  issued pixel row
- vcount_axis_tvalid  out  1  issue valid, identical to hcount_axis_tvalid
- vcount_axis_tready  in  1  renderer accepts vcount
- select_objs  out  2  latched select code, constant for the whole frame
- pixel_axis_tdata  in  24  returned RGB pixel
- pixel_axis_tvalid  in  1  returned pixel valid
- pixel_axis_tready  out  1  equals fb_ready
- hcount_in  in  11  column tag of the returned pixel
- vcount_in  in  10  row tag of the returned pixel
- fb_addr  out  FB_ADDR_W  framebuffer write address
- fb_data  out  24  framebuffer write data
- fb_we  out  1  framebuffer write strobe
- fb_ready  in  1  framebuffer can accept a write

Behaviour:
- Reset (async, any state): state=IDLE.
  - All outputs 0: tvalids, busy, frame_done, fb_we, fb_addr, fb_data, select_objs.
  - Internal h/v counters 0, inflight=0, issued-count 0.
- States:
  - IDLE: start=1 latches select_objs_cfg, clears counters, goes to ISSUE next cycle.
  - ISSUE: go to DRAIN after the handshake of pixel (H_ACTIVE-1, V_ACTIVE-1).
  - DRAIN: go to DONE when inflight==0.
  - DONE: frame_done=1 for exactly one cycle, then IDLE.
  - start outside IDLE is ignored.
- Issue:
  - In ISSUE, tvalid=1 iff inflight < MAX_INFLIGHT.
  - Handshake (issue_fire) = tvalid & hcount_axis_tready & vcount_axis_tready.
  - tdata and tvalid are held stable until issue_fire; tvalid never drops without a fire unless reset.
  - Order is raster: h increments per fire, wraps to 0 at H_ACTIVE-1 with v+1.
  - The last pixel fire drops tvalid the next cycle.
- Credits:
  - inflight is $clog2(MAX_INFLIGHT+1) bits.
  - +1 on issue_fire; -1 on ret_fire = pixel_axis_tvalid & pixel_axis_tready.
  - Both in the same cycle: unchanged.
  - ret_fire at inflight==0 is a protocol error: ignored and counter saturates at 0.
- Return path:
  - On ret_fire, registered (1-cycle latency): fb_we=1, fb_data=pixel_axis_tdata, fb_addr=vcount_in*H_ACTIVE+hcount_in, truncated to FB_ADDR_W.
  - fb_we is 0 in any cycle without ret_fire.
  - Returns are accepted in any state, including IDLE.
- Frame latency: frame_done asserts the cycle after the last ret_fire drives inflight to 0 in DRAIN, at the earliest (H_ACTIVE*V_ACTIVE) + renderer latency + 2 cycles after start.
- busy is registered from state: 1 in ISSUE/DRAIN.

Test Plan:
- H_ACTIVE=4, V_ACTIVE=2, readies tied 1, renderer model with 5-cycle delay, start pulse -> 8 issues in order (0,0)..(3,1) on consecutive cycles; fb_addr 0..7 with matching data; exactly one frame_done after the 8th write; busy low afterwards.
- Toggle hcount/vcount tready randomly -> tdata held stable across stalls, no duplicated or skipped coordinate, final inflight 0.
- MAX_INFLIGHT=3, renderer never returns -> exactly 3 fires, tvalid low, state holds ISSUE; release returns -> issue resumes one per credit.
- Issue and return fire in the same cycle at inflight=2 -> inflight stays 2; fb_we=1 the next cycle.
- start asserted mid-frame with a different select_objs_cfg -> ignored; select_objs unchanged until the next IDLE start.
- areset asserted during DRAIN with inflight=5 -> immediate IDLE, all outputs 0, no frame_done; next start renders a full frame correctly.

Source files
------------

// File: rtl/render_scheduler.sv
// Frame-level issue/return controller for the ray-tracing renderer: sweeps the frame in raster order
// under a credit limit, writes returned pixels to the framebuffer and pulses frame_done when drained.
module render_scheduler #(
    parameter int H_ACTIVE     = 320,
    parameter int V_ACTIVE     = 180,
    parameter int MAX_INFLIGHT = 384,
    parameter int FB_ADDR_W    = 16
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 start,
    input  logic [1:0]           select_objs_cfg,
    output logic                 busy,
    output logic                 frame_done,
    output logic [10:0]          hcount_axis_tdata,
    output logic                 hcount_axis_tvalid,
    input  logic                 hcount_axis_tready,
    output logic [9:0]           vcount_axis_tdata,
    output logic                 vcount_axis_tvalid,
    input  logic                 vcount_axis_tready,
    output logic [1:0]           select_objs,
    input  logic [23:0]          pixel_axis_tdata,
    input  logic                 pixel_axis_tvalid,
    output logic                 pixel_axis_tready,
    input  logic [10:0]          hcount_in,
    input  logic [9:0]           vcount_in,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [23:0]          fb_data,
    output logic                 fb_we,
    input  logic                 fb_ready
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_reg;
    logic [10:0]      h_reg;
    logic [9:0]       v_reg;
    logic [CNT_W-1:0] inflight_reg;
    logic [CNT_W-1:0] inflight_next;

    logic        issue_valid;
    logic        issue_fire;
    logic        ret_fire;
    logic        last_pixel;
    logic        last_column;
    logic [31:0] addr_full;

    assign issue_valid = (state_reg == S_ISSUE) && (inflight_reg < CNT_W'(MAX_INFLIGHT));
    assign issue_fire  = issue_valid && hcount_axis_tready && vcount_axis_tready;
    assign ret_fire    = pixel_axis_tvalid && fb_ready;
    assign last_column = (h_reg == 11'(H_ACTIVE - 1));
    assign last_pixel  = last_column && (v_reg == 10'(V_ACTIVE - 1));
    assign addr_full   = 32'(vcount_in) * 32'(H_ACTIVE) + 32'(hcount_in);

    assign hcount_axis_tdata  = h_reg;
    assign vcount_axis_tdata  = v_reg;
    assign hcount_axis_tvalid = issue_valid;
    assign vcount_axis_tvalid = issue_valid;
    assign pixel_axis_tready  = fb_ready;

    // A stray return with nothing outstanding is dropped so the credit count cannot wrap.
    always_comb begin
        inflight_next = inflight_reg;
        if (issue_fire && !ret_fire) begin
            inflight_next = inflight_reg + CNT_W'(1);
        end else if (!issue_fire && ret_fire && (inflight_reg != '0)) begin
            inflight_next = inflight_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_reg    <= S_IDLE;
            h_reg        <= '0;
            v_reg        <= '0;
            inflight_reg <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            select_objs  <= '0;
            fb_we        <= 1'b0;
            fb_addr      <= '0;
            fb_data      <= '0;
        end else begin
            inflight_reg <= inflight_next;
            frame_done   <= 1'b0;
            fb_we        <= ret_fire;
            if (ret_fire) begin
                fb_data <= pixel_axis_tdata;
                fb_addr <= addr_full[FB_ADDR_W-1:0];
            end

            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        select_objs <= select_objs_cfg;
                        h_reg       <= '0;
                        v_reg       <= '0;
                        busy        <= 1'b1;
                        state_reg   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (issue_fire) begin
                        if (last_pixel) begin
                            state_reg <= S_DRAIN;
                        end else if (last_column) begin
                            h_reg <= '0;
                            v_reg <= v_reg + 10'd1;
                        end else begin
                            h_reg <= h_reg + 11'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (inflight_reg == '0) begin
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state_reg  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_render_scheduler.sv
// Bench for render_scheduler on a 4x2 frame: a delayed renderer model drives the main instance,
// a second instance with three credits is driven by hand for the credit and handshake corners.
module tb_render_scheduler;

    localparam int DELAY = 5;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    // main instance signals
    logic        areset, start, busy, frame_done;
    logic [1:0]  cfg, sel;
    logic [10:0] htd, hin;
    logic [9:0]  vtd, vin;
    logic        hv, vv, hr, vr, pv, pr, fb_we, fbr;
    logic [23:0] ptd, fb_data;
    logic [15:0] fb_addr;

    // credit-limited instance signals
    logic        s_start, s_busy, s_done;
    logic [1:0]  s_cfg, s_sel;
    logic [10:0] s_htd, s_hin;
    logic [9:0]  s_vtd, s_vin;
    logic        s_hv, s_vv, s_hr, s_pv, s_pr, s_fb_we, s_fbr;
    logic [23:0] s_ptd, s_fb_data;
    logic [15:0] s_fb_addr;

    render_scheduler #(.H_ACTIVE(4), .V_ACTIVE(2), .MAX_INFLIGHT(8), .FB_ADDR_W(16)) dut (
        .aclk(aclk), .areset(areset), .start(start), .select_objs_cfg(cfg),
        .busy(busy), .frame_done(frame_done),
        .hcount_axis_tdata(htd), .hcount_axis_tvalid(hv), .hcount_axis_tready(hr),
        .vcount_axis_tdata(vtd), .vcount_axis_tvalid(vv), .vcount_axis_tready(vr),
        .select_objs(sel), .pixel_axis_tdata(ptd), .pixel_axis_tvalid(pv), .pixel_axis_tready(pr),
        .hcount_in(hin), .vcount_in(vin), .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we),
        .fb_ready(fbr));

    render_scheduler #(.H_ACTIVE(4), .V_ACTIVE(2), .MAX_INFLIGHT(3), .FB_ADDR_W(16)) dut_small (
        .aclk(aclk), .areset(areset), .start(s_start), .select_objs_cfg(s_cfg),
        .busy(s_busy), .frame_done(s_done),
        .hcount_axis_tdata(s_htd), .hcount_axis_tvalid(s_hv), .hcount_axis_tready(s_hr),
        .vcount_axis_tdata(s_vtd), .vcount_axis_tvalid(s_vv), .vcount_axis_tready(s_hr),
        .select_objs(s_sel), .pixel_axis_tdata(s_ptd), .pixel_axis_tvalid(s_pv),
        .pixel_axis_tready(s_pr), .hcount_in(s_hin), .vcount_in(s_vin), .fb_addr(s_fb_addr),
        .fb_data(s_fb_data), .fb_we(s_fb_we), .fb_ready(s_fbr));

    typedef struct {
        logic [10:0] h;
        logic [9:0]  v;
        logic [15:0] addr;
        logic [23:0] data;
    } vec_t;
    typedef struct { logic [10:0] h; logic [9:0] v; int c; } iss_t;
    typedef struct { logic [15:0] a; logic [23:0] d; int c; } wr_t;
    typedef struct { logic [10:0] h; logic [9:0] v; int due; } job_t;

    vec_t vec [8];
    iss_t iss_q[$];
    wr_t  wr_q[$];
    job_t q[$];

    int cyc = 0;
    int rets_done = 0;
    int ret_limit = 1000000;
    int done_cnt = 0;
    int done_cyc = 0;
    int stall_err = 0;
    int s_fires = 0;
    int s_done_cnt = 0;
    logic flush = 1'b0;
    logic prev_stall = 1'b0;
    logic [10:0] prev_h;
    logic [9:0]  prev_v;

    int n_pass = 0;
    int n_total = 0;

    function automatic logic [23:0] pix(input logic [10:0] h, input logic [9:0] v);
        return 24'hC00000 + {6'd0, v, 8'd0} + {13'd0, h};
    endfunction

    // Renderer model plus monitors; observes pre-edge values, drives returns 1 time unit later.
    always @(posedge aclk) begin
        cyc = cyc + 1;
        if (flush) begin
            q.delete();
        end else begin
            if (pv && fbr) begin
                if (q.size() > 0) void'(q.pop_front());
                rets_done = rets_done + 1;
            end
            if (hv && hr && vr) q.push_back('{htd, vtd, cyc + DELAY});
        end
        if (hv && hr && vr) iss_q.push_back('{htd, vtd, cyc});
        if (fb_we) wr_q.push_back('{fb_addr, fb_data, cyc});
        if (frame_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (!areset && prev_stall && (!hv || htd != prev_h || vtd != prev_v))
            stall_err = stall_err + 1;
        prev_stall = !areset && hv && !(hr && vr);
        prev_h = htd;
        prev_v = vtd;
        if (s_hv && s_hr) s_fires = s_fires + 1;
        if (s_done) s_done_cnt = s_done_cnt + 1;
        #1;
        if (q.size() > 0 && q[0].due <= cyc && rets_done < ret_limit) begin
            pv  = 1'b1;
            ptd = pix(q[0].h, q[0].v);
            hin = q[0].h;
            vin = q[0].v;
        end else begin
            pv = 1'b0;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_total = n_total + 1;
        if (act == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic pulse_start(input logic [1:0] c, output int sc);
        @(negedge aclk);
        start = 1'b1;
        cfg   = c;
        sc    = cyc + 1;
        @(negedge aclk);
        start = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge aclk);
            n++;
        end
        check("frame_done_timeout", longint'(done_cnt >= target), 1);
        wait_cycles(3);
    endtask

    task automatic check_frame(input int bi, input int bw, input int sc, input bit timed);
        check("issue_count", iss_q.size() - bi, 8);
        check("write_count", wr_q.size() - bw, 8);
        for (int i = 0; i < 8; i++) begin
            if (bi + i < iss_q.size()) begin
                check($sformatf("issue_h[%0d]", i), iss_q[bi+i].h, vec[i].h);
                check($sformatf("issue_v[%0d]", i), iss_q[bi+i].v, vec[i].v);
                if (timed) check($sformatf("issue_cycle[%0d]", i), iss_q[bi+i].c, sc + 1 + i);
            end
            if (bw + i < wr_q.size()) begin
                check($sformatf("fb_addr[%0d]", i), wr_q[bw+i].a, vec[i].addr);
                check($sformatf("fb_data[%0d]", i), wr_q[bw+i].d, vec[i].data);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bi, bw, sc, n;
        vec[0] = '{11'd0, 10'd0, 16'd0, 24'hC00000};
        vec[1] = '{11'd1, 10'd0, 16'd1, 24'hC00001};
        vec[2] = '{11'd2, 10'd0, 16'd2, 24'hC00002};
        vec[3] = '{11'd3, 10'd0, 16'd3, 24'hC00003};
        vec[4] = '{11'd0, 10'd1, 16'd4, 24'hC00100};
        vec[5] = '{11'd1, 10'd1, 16'd5, 24'hC00101};
        vec[6] = '{11'd2, 10'd1, 16'd6, 24'hC00102};
        vec[7] = '{11'd3, 10'd1, 16'd7, 24'hC00103};

        areset = 1'b1; start = 1'b0; cfg = 2'd0; hr = 1'b1; vr = 1'b1; fbr = 1'b1;
        pv = 1'b0; ptd = '0; hin = '0; vin = '0;
        s_start = 1'b0; s_cfg = 2'd0; s_hr = 1'b0; s_pv = 1'b0; s_ptd = '0;
        s_hin = '0; s_vin = '0; s_fbr = 1'b1;
        wait_cycles(2);
        check("reset_busy", busy, 0);
        check("reset_frame_done", frame_done, 0);
        check("reset_tvalid", longint'({hv, vv, s_hv, s_vv}), 0);
        check("reset_fb_we", fb_we, 0);
        check("reset_fb_addr", fb_addr, 0);
        check("reset_fb_data", fb_data, 0);
        check("reset_select_objs", sel, 0);
        @(negedge aclk);
        areset = 1'b0;

        // frame 1: all readies high, fixed-latency renderer
        bi = iss_q.size(); bw = wr_q.size();
        pulse_start(2'd1, sc);
        wait_frames(1, 200);
        check_frame(bi, bw, sc, 1'b1);
        if (wr_q.size() >= bw + 8) check("done_after_last_write", done_cyc, wr_q[bw+7].c + 1);
        check("f1_done_count", done_cnt, 1);
        check("f1_busy_after", busy, 0);
        check("f1_select_objs", sel, 1);

        // frame 2: random backpressure, plus a mid-frame start that must be ignored
        bi = iss_q.size(); bw = wr_q.size();
        pulse_start(2'd3, sc);
        n = 0;
        while (done_cnt < 2 && n < 400) begin
            @(negedge aclk);
            hr = 1'($urandom_range(0, 1));
            vr = 1'($urandom_range(0, 1));
            start = (n == 5);
            cfg = (n == 5) ? 2'd2 : 2'd3;
            if (n == 10) check("f2_busy_mid", busy, 1);
            n++;
        end
        start = 1'b0; hr = 1'b1; vr = 1'b1;
        check("f2_timeout", longint'(done_cnt >= 2), 1);
        wait_cycles(3);
        check_frame(bi, bw, sc, 1'b0);
        check("f2_stall_stability", stall_err, 0);
        check("f2_select_objs_kept", sel, 3);
        check("f2_done_count", done_cnt, 2);

        // frame 3: only three returns, then reset in DRAIN with five outstanding
        bi = iss_q.size();
        ret_limit = rets_done + 3;
        pulse_start(2'd2, sc);
        check("f3_select_objs", sel, 2);
        n = 0;
        while ((iss_q.size() - bi < 8 || rets_done < ret_limit) && n < 100) begin
            @(negedge aclk);
            n++;
        end
        wait_cycles(4);
        check("f3_busy_in_drain", busy, 1);
        check("f3_no_done_yet", done_cnt, 2);
        areset = 1'b1;
        flush  = 1'b1;
        #1;
        check("async_reset_busy", busy, 0);
        check("async_reset_tvalid", hv, 0);
        check("async_reset_select_objs", sel, 0);
        check("async_reset_fb_addr", fb_addr, 0);
        check("async_reset_frame_done", frame_done, 0);
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        flush = 1'b0;
        ret_limit = 1000000;
        wait_cycles(6);
        check("no_done_after_reset", done_cnt, 2);

        // frame 4: full frame after the reset
        bi = iss_q.size(); bw = wr_q.size();
        pulse_start(2'd1, sc);
        wait_frames(3, 200);
        check_frame(bi, bw, sc, 1'b1);
        check("f4_select_objs", sel, 1);
        check("f4_busy_after", busy, 0);

        // credit-limited instance: renderer holds everything
        @(negedge aclk);
        s_hr = 1'b1; s_start = 1'b1; s_cfg = 2'd1;
        @(negedge aclk);
        s_start = 1'b0;
        wait_cycles(6);
        check("credit_fires", s_fires, 3);
        check("credit_tvalid_low", s_hv, 0);
        check("credit_busy", s_busy, 1);
        check("credit_held_coord", longint'({s_htd, s_vtd}), longint'({11'd3, 10'd0}));

        // one return releases exactly one issue
        s_pv = 1'b1; s_hin = 11'd0; s_vin = 10'd0; s_ptd = 24'h111111;
        @(negedge aclk);
        s_pv = 1'b0;
        check("ret_fb_we", s_fb_we, 1);
        check("ret_fb_data", s_fb_data, 24'h111111);
        wait_cycles(3);
        check("resume_fires", s_fires, 4);
        check("resume_tvalid_low", s_hv, 0);
        check("resume_next_coord", longint'({s_htd, s_vtd}), longint'({11'd0, 10'd1}));

        // drop to two outstanding, then issue and return in the same cycle
        s_hr = 1'b0; s_pv = 1'b1; s_hin = 11'd1; s_vin = 10'd0; s_ptd = 24'h222222;
        @(negedge aclk);
        s_hr = 1'b1; s_pv = 1'b1; s_hin = 11'd2; s_vin = 10'd0; s_ptd = 24'h333333;
        s_start = 1'b1; s_cfg = 2'd2;
        @(negedge aclk);
        s_pv = 1'b0; s_start = 1'b0;
        check("same_cycle_fb_we", s_fb_we, 1);
        check("same_cycle_fb_addr", s_fb_addr, 2);
        check("same_cycle_fb_data", s_fb_data, 24'h333333);
        check("same_cycle_fires", s_fires, 5);
        check("same_cycle_tvalid", s_hv, 1);
        wait_cycles(3);
        check("one_credit_left", s_fires, 6);
        check("credit_tvalid_low2", s_hv, 0);
        check("mid_start_ignored", s_sel, 1);

        // keep returning (including surplus returns at zero outstanding) until done
        s_pv = 1'b1; s_hin = 11'd3; s_vin = 10'd1; s_ptd = 24'h444444;
        wait_cycles(12);
        s_pv = 1'b0;
        check("last_ret_fb_addr", s_fb_addr, 7);
        wait_cycles(3);
        check("small_done_count", s_done_cnt, 1);
        check("small_busy_after", s_busy, 0);
        check("small_total_fires", s_fires, 8);

        // surplus returns must not have wrapped the credit counter
        @(negedge aclk);
        s_start = 1'b1; s_cfg = 2'd2;
        @(negedge aclk);
        s_start = 1'b0;
        wait_cycles(6);
        check("saturated_fires", s_fires, 11);
        check("saturated_tvalid_low", s_hv, 0);
        check("new_frame_select_objs", s_sel, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
